// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Upstream driver for a 4-digit seven-segment display stage.
//               A programmable prescaler advances a 2-bit digit-scan index.
//               New display words from a CPU producer arrive through a
//               valid/ready handshake into a one-entry shadow buffer. The
//               word is committed to disp_num only at a frame boundary, so
//               the display never tears mid-frame.
// Ports       : clk        - system clock, rising edge
//               clr        - asynchronous active-low reset
//               ld_valid   - producer offers ld_data this cycle
//               ld_data    - 32-bit word to display
//               ld_ready   - shadow buffer empty (registered)
//               hold       - freeze prescaler and scan index
//               disp_num   - committed display word (registered)
//               Scanning   - digit index 0..3 (registered)
//               frame_tick - one-cycle pulse when Scanning wraps 3->0
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int          SCAN_DIV = 50000,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        hold,
  output logic [31:0] disp_num,
  output logic [1:0]  Scanning,
  output logic        frame_tick
);

  // $clog2(1) is 0, so the divider counter is kept at least one bit wide.
  localparam int               DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       scan_q, scan_d;
  logic             tick_q, tick_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pend_q, pend_d;

  logic             w_step;
  logic             w_boundary;
  logic             w_accept;
  logic             w_commit;

  assign w_step     = (div_cnt_q == DIV_MAX) & ~hold;
  assign w_boundary = w_step & (scan_q == 2'd3);
  // Ready comes straight from pend_q, so accept never feeds back into ready.
  assign w_accept   = ld_valid & ~pend_q;
  assign w_commit   = w_boundary & pend_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_cnt_q <= '0;
      scan_q    <= 2'd0;
      tick_q    <= 1'b0;
      disp_q    <= INIT_VAL;
      shadow_q  <= 32'h0;
      pend_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      scan_q    <= scan_d;
      tick_q    <= tick_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and scan index
  // ---------------------------------------------------------------------------
  always_comb begin
    div_cnt_d = div_cnt_q;
    scan_d    = scan_q;
    if (!hold) begin
      if (div_cnt_q == DIV_MAX) begin
        div_cnt_d = '0;
        scan_d    = scan_q + 2'd1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  // Boundary already excludes hold, so the pulse is suppressed while frozen.
  always_comb begin
    tick_d = w_boundary;
  end

  // ---------------------------------------------------------------------------
  // Shadow buffer and commit
  // ---------------------------------------------------------------------------
  // Accept and commit are mutually exclusive: accept needs pend_q=0, commit
  // needs pend_q=1. An accept on a boundary edge therefore only fills the
  // shadow; there is no bypass to the display word.
  always_comb begin
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (w_commit) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
    if (w_accept) begin
      shadow_d = ld_data;
      pend_d   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_ready   = ~pend_q;
    disp_num   = disp_q;
    Scanning   = scan_q;
    frame_tick = tick_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl (SCAN_DIV=4, INIT=0).
//               Directed vector table, hand-written corner sequences and a
//               randomized run against a frame-phase reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int          DIV   = 4;
  localparam int          FRAME = 4 * DIV;
  localparam logic [31:0] INIT  = 32'h0000_0000;

  logic        clk;
  logic        clr;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        hold;
  logic [31:0] disp_num;
  logic [1:0]  Scanning;
  logic        frame_tick;

  seg_scan_ctrl #(.SCAN_DIV(DIV), .INIT_VAL(INIT)) dut (
    .clk       (clk),
    .clr       (clr),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .hold      (hold),
    .disp_num  (disp_num),
    .Scanning  (Scanning),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one counter of non-held cycles within the frame.
  int          m_phase;
  logic        m_pend;
  logic [31:0] m_shadow;
  logic [31:0] m_disp;
  logic        m_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_pend   = 1'b0;
    m_shadow = 32'h0;
    m_disp   = INIT;
    m_tick   = 1'b0;
  endtask

  task automatic model_edge();
    logic bnd;
    logic old_pend;
    bnd      = !hold && (m_phase == FRAME - 1);
    old_pend = m_pend;
    m_tick   = bnd;
    if (bnd && old_pend) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end
    if (ld_valid && !old_pend) begin
      m_shadow = ld_data;
      m_pend   = 1'b1;
    end
    if (!hold) m_phase = (m_phase + 1) % FRAME;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".scan"},  {30'd0, Scanning}, 32'(m_phase / DIV));
    chk({tag, ".disp"},  disp_num,          m_disp);
    chk({tag, ".ready"}, {31'd0, ld_ready}, {31'd0, ~m_pend});
    chk({tag, ".tick"},  {31'd0, frame_tick}, {31'd0, m_tick});
  endtask

  // One clock edge, model update, then sample 1 time unit after the edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_model(tag);
  endtask

  // Asynchronous reset asserted between edges, checked with no edge.
  task automatic async_reset(input string tag);
    #2;
    clr = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_scan"},  {30'd0, Scanning},   32'd0);
    chk({tag, ".rst_disp"},  disp_num,            INIT);
    chk({tag, ".rst_ready"}, {31'd0, ld_ready},   32'd1);
    chk({tag, ".rst_tick"},  {31'd0, frame_tick}, 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        h;
    logic [1:0]  scan;
    logic [31:0] disp;
    logic        rdy;
    logic        tick;
  } vec_t;

  vec_t vec[17];

  initial begin
    logic [31:0] prev;
    logic        found;
    int          rem;

    // Expected outputs after edge k+1 following reset release.
    vec[0]  = '{1'b0, 32'h0,         1'b0, 2'd0, 32'h0,         1'b1, 1'b0};
    vec[1]  = '{1'b0, 32'h0,         1'b0, 2'd0, 32'h0,         1'b1, 1'b0};
    vec[2]  = '{1'b0, 32'h0,         1'b0, 2'd0, 32'h0,         1'b1, 1'b0};
    vec[3]  = '{1'b0, 32'h0,         1'b0, 2'd1, 32'h0,         1'b1, 1'b0};
    vec[4]  = '{1'b1, 32'h1234_ABCD, 1'b0, 2'd1, 32'h0,         1'b0, 1'b0};
    vec[5]  = '{1'b0, 32'h0,         1'b0, 2'd1, 32'h0,         1'b0, 1'b0};
    vec[6]  = '{1'b0, 32'h0,         1'b0, 2'd1, 32'h0,         1'b0, 1'b0};
    vec[7]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0};
    vec[8]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0};
    vec[9]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0};
    vec[10] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0};
    vec[11] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd3, 32'h0,         1'b0, 1'b0};
    vec[12] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd3, 32'h0,         1'b0, 1'b0};
    vec[13] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd3, 32'h0,         1'b0, 1'b0};
    vec[14] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd3, 32'h0,         1'b0, 1'b0};
    vec[15] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd0, 32'h1234_ABCD, 1'b1, 1'b1};
    vec[16] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd0, 32'h1234_ABCD, 1'b0, 1'b0};

    clr = 1'b0; ld_valid = 1'b0; ld_data = 32'h0; hold = 1'b0;
    model_reset();
    #3;
    chk("reset.scan",  {30'd0, Scanning},   32'd0);
    chk("reset.disp",  disp_num,            INIT);
    chk("reset.ready", {31'd0, ld_ready},   32'd1);
    chk("reset.tick",  {31'd0, frame_tick}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 1'b1;

    // Directed table: first frame, first load, blocked second load.
    for (int i = 0; i < 17; i++) begin
      ld_valid = vec[i].v;
      ld_data  = vec[i].d;
      hold     = vec[i].h;
      cyc("vec_model");
      chk($sformatf("vec%0d.scan", i),  {30'd0, Scanning},   {30'd0, vec[i].scan});
      chk($sformatf("vec%0d.disp", i),  disp_num,            vec[i].disp);
      chk($sformatf("vec%0d.ready", i), {31'd0, ld_ready},   {31'd0, vec[i].rdy});
      chk($sformatf("vec%0d.tick", i),  {31'd0, frame_tick}, {31'd0, vec[i].tick});
    end

    // DEADBEEF was accepted at edge 17; it shows at edge 32.
    ld_valid = 1'b0;
    repeat (14) cyc("t3_wait");
    chk("t3.disp_before", disp_num, 32'h1234_ABCD);
    cyc("t3_commit");
    chk("t3.disp_after", disp_num, 32'hDEAD_BEEF);
    chk("t3.tick", {31'd0, frame_tick}, 32'd1);

    // Accept exactly on a boundary edge: shadow only, commit one frame later.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_phase == FRAME - 1 && !m_pend) found = 1'b1;
      else cyc("t4_seek");
    end
    chk("t4.found_boundary", {31'd0, found}, 32'd1);
    prev     = disp_num;
    ld_valid = 1'b1;
    ld_data  = 32'h0000_00FF;
    cyc("t4_accept");
    chk("t4.no_bypass", disp_num, prev);
    chk("t4.tick", {31'd0, frame_tick}, 32'd1);
    chk("t4.ready", {31'd0, ld_ready}, 32'd0);
    ld_valid = 1'b0;
    repeat (15) cyc("t4_wait");
    chk("t4.disp_before", disp_num, prev);
    cyc("t4_commit");
    chk("t4.disp_after", disp_num, 32'h0000_00FF);

    // Hold at Scanning=2 with a pending word.
    ld_valid = 1'b1;
    ld_data  = 32'hCAFE_0005;
    cyc("t5_load");
    ld_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_phase == 2 * DIV + 1) found = 1'b1;
      else cyc("t5_seek");
    end
    chk("t5.found_phase", {31'd0, found}, 32'd1);
    rem  = DIV - 1 - (m_phase % DIV);
    prev = disp_num;
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc("t5_hold");
      chk("t5.scan_frozen", {30'd0, Scanning}, 32'd2);
      chk("t5.tick_zero", {31'd0, frame_tick}, 32'd0);
      chk("t5.no_commit", disp_num, prev);
    end
    hold = 1'b0;
    repeat (rem) cyc("t5_resume");
    chk("t5.scan_before_step", {30'd0, Scanning}, 32'd2);
    cyc("t5_step");
    chk("t5.scan_after_step", {30'd0, Scanning}, 32'd3);
    repeat (DIV) cyc("t5_commit");
    chk("t5.committed", disp_num, 32'hCAFE_0005);

    // Mid-frame reset with a pending word: the word must be discarded.
    ld_valid = 1'b1;
    ld_data  = 32'h1234_ABCD;
    cyc("t6_load");
    ld_valid = 1'b0;
    cyc("t6_run");
    async_reset("t6");
    repeat (2 * FRAME) cyc("t6_after");
    chk("t6.shadow_discarded", disp_num, INIT);

    // Randomized run against the reference model.
    for (int i = 0; i < 600; i++) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = $urandom;
      hold     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) async_reset("rnd");
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
